// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes, immediate
// formats, writeback source codes and the decoded-control bundle.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;

    typedef struct packed {
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      branch;
        logic      jump;
        logic      alu_src;
        logic [1:0] result_src;
        alu_ctrl_e alu_ctrl;
        imm_type_e imm_type;
        logic      rs1_used;
        logic      rs2_used;
        logic      illegal;
    } ctrl_t;

    // funct3/funct7[5] to ALU op; SUB only exists for register-register ops,
    // while bit 30 selects SRA for both the shift-immediate and register forms.
    function automatic alu_ctrl_e alu_from_funct(input logic [2:0] funct3,
                                                 input logic       f7b5,
                                                 input logic       is_op);
        alu_ctrl_e op;
        case (funct3)
            3'b000:  op = (is_op && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Signal bundle between fetch, register file, writeback and the ID/EX stage.
//
// Handshake: the stage accepts if_instr/if_pc on a rising edge when
// if_valid=1 and (stall | hazard_stall)=0; otherwise the upstream stage must
// hold its instruction unchanged. ex_valid marks the EX registers as holding
// a live instruction; flush kills whatever would enter EX on that edge.
interface id_ex_stage_if;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        stall;
    logic        flush;
    logic [4:0]  rf_a1;
    logic [4:0]  rf_a2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        hazard_stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [3:0]  ex_alu_ctrl;
    logic        ex_alu_src;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_jump;
    logic [1:0]  ex_result_src;
    logic        ex_illegal;

    modport master (
        output if_valid, if_instr, if_pc, stall, flush,
        output rf_rd1, rf_rd2, wb_we, wb_rd, wb_data,
        input  rf_a1, rf_a2, hazard_stall,
        input  ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
        input  ex_rs1, ex_rs2, ex_rd, ex_alu_ctrl, ex_alu_src,
        input  ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
        input  ex_jump, ex_result_src, ex_illegal
    );

    modport slave (
        input  if_valid, if_instr, if_pc, stall, flush,
        input  rf_rd1, rf_rd2, wb_we, wb_rd, wb_data,
        output rf_a1, rf_a2, hazard_stall,
        output ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm,
        output ex_rs1, ex_rs2, ex_rd, ex_alu_ctrl, ex_alu_src,
        output ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
        output ex_jump, ex_result_src, ex_illegal
    );
endinterface

// File: rtl/id_ex_stage_imm_gen.sv
// Immediate generator: sign-extends the immediate field of an RV32I
// instruction according to its format. Bits [6:0] carry no immediate data.
module imm_gen
    import rv32i_pkg::*;
(
    input  logic [31:7] instr_i,
    input  imm_type_e   imm_type_i,
    output logic [31:0] imm_o
);

    // Reassemble the scattered immediate bits for the selected format.
    always_comb begin
        imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
        case (imm_type_i)
            IMM_S: imm_o = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm_o = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm_o = {instr_i[31:12], 12'b0};
            IMM_J: imm_o = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: imm_o = {{20{instr_i[31]}}, instr_i[31:20]};
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode stage with the ID/EX pipeline register: decodes the fetched
// instruction, bypasses a same-cycle writeback into the operands, detects
// load-use hazards and inserts a bubble.
module id_ex_stage
    import rv32i_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic         clk,
    input logic         rst,
    id_ex_stage_if.slave bus
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1_raw;
    logic [4:0]      rs2_raw;
    logic [4:0]      rd_raw;
    ctrl_t           dec;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_idx;
    logic [4:0]      rs2_idx;
    logic [4:0]      rd_idx;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            hazard;

    logic            ex_valid_d,      ex_valid_q;
    logic [XLEN-1:0] ex_pc_d,         ex_pc_q;
    logic [XLEN-1:0] ex_rs1_val_d,    ex_rs1_val_q;
    logic [XLEN-1:0] ex_rs2_val_d,    ex_rs2_val_q;
    logic [XLEN-1:0] ex_imm_d,        ex_imm_q;
    logic [4:0]      ex_rs1_d,        ex_rs1_q;
    logic [4:0]      ex_rs2_d,        ex_rs2_q;
    logic [4:0]      ex_rd_d,         ex_rd_q;
    alu_ctrl_e       ex_alu_ctrl_d,   ex_alu_ctrl_q;
    logic            ex_alu_src_d,    ex_alu_src_q;
    logic            ex_reg_write_d,  ex_reg_write_q;
    logic            ex_mem_read_d,   ex_mem_read_q;
    logic            ex_mem_write_d,  ex_mem_write_q;
    logic            ex_branch_d,     ex_branch_q;
    logic            ex_jump_d,       ex_jump_q;
    logic [1:0]      ex_result_src_d, ex_result_src_q;
    logic            ex_illegal_d,    ex_illegal_q;

    assign opcode  = bus.if_instr[6:0];
    assign rd_raw  = bus.if_instr[11:7];
    assign funct3  = bus.if_instr[14:12];
    assign rs1_raw = bus.if_instr[19:15];
    assign rs2_raw = bus.if_instr[24:20];

    // Register-file addresses come straight from the instruction word.
    assign bus.rf_a1 = rs1_raw;
    assign bus.rf_a2 = rs2_raw;

    // Main decoder: control fields per opcode; unknown opcodes are illegal
    // with every write and memory enable left at 0.
    always_comb begin
        dec            = '0;
        dec.alu_ctrl   = ALU_ADD;
        dec.imm_type   = IMM_I;
        dec.result_src = RES_ALU;
        dec.rs1_used   = 1'b1;
        case (opcode)
            OP_LUI: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = ALU_PASSB;
                dec.imm_type  = IMM_U;
                dec.rs1_used  = 1'b0;
            end
            OP_AUIPC: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_type  = IMM_U;
                dec.rs1_used  = 1'b0;
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_PC4;
                dec.imm_type   = IMM_J;
                dec.rs1_used   = 1'b0;
            end
            OP_JALR: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_PC4;
            end
            OP_BRANCH: begin
                dec.branch   = 1'b1;
                dec.alu_ctrl = ALU_SUB;
                dec.imm_type = IMM_B;
                dec.rs2_used = 1'b1;
            end
            OP_LOAD: begin
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.alu_src    = 1'b1;
                dec.result_src = RES_MEM;
            end
            OP_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm_type  = IMM_S;
                dec.rs2_used  = 1'b1;
            end
            OP_IMM: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.alu_ctrl  = alu_from_funct(funct3, bus.if_instr[30], 1'b0);
            end
            OP_OP: begin
                dec.reg_write = 1'b1;
                dec.rs2_used  = 1'b1;
                dec.alu_ctrl  = alu_from_funct(funct3, bus.if_instr[30], 1'b1);
            end
            OP_FENCE, OP_SYSTEM: begin
                // Executed as a NOP: nothing written, no memory access.
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    imm_gen u_imm_gen (
        .instr_i    (bus.if_instr[31:7]),
        .imm_type_i (dec.imm_type),
        .imm_o      (imm)
    );

    // Unused register indices collapse to x0 so they never match a hazard or
    // a bypass, and rd is zero for instructions that do not write it.
    assign rs1_idx = dec.rs1_used  ? rs1_raw : 5'd0;
    assign rs2_idx = dec.rs2_used  ? rs2_raw : 5'd0;
    assign rd_idx  = dec.reg_write ? rd_raw  : 5'd0;

    // Operand select: x0 reads as zero, otherwise a same-cycle writeback to
    // the source register wins over the (not yet updated) register file.
    always_comb begin
        rs1_val = bus.rf_rd1;
        rs2_val = bus.rf_rd2;
        if (rs1_idx == 5'd0) begin
            rs1_val = '0;
        end else if (bus.wb_we && (bus.wb_rd == rs1_idx)) begin
            rs1_val = bus.wb_data;
        end
        if (rs2_idx == 5'd0) begin
            rs2_val = '0;
        end else if (bus.wb_we && (bus.wb_rd == rs2_idx)) begin
            rs2_val = bus.wb_data;
        end
    end

    // Load-use hazard: the load in EX produces its data too late for the
    // instruction being decoded. Masked during a downstream stall, since the
    // upstream stage is already holding then.
    always_comb begin
        hazard = bus.if_valid && ex_valid_q && ex_mem_read_q &&
                 (ex_rd_q != 5'd0) &&
                 ((dec.rs1_used && (ex_rd_q == rs1_raw)) ||
                  (dec.rs2_used && (ex_rd_q == rs2_raw))) &&
                 !bus.stall;
    end

    assign bus.hazard_stall = hazard;

    // Next state of the EX registers: flush, then stall, then bubble, then
    // capture of the decoded instruction.
    always_comb begin
        ex_valid_d      = ex_valid_q;
        ex_pc_d         = ex_pc_q;
        ex_rs1_val_d    = ex_rs1_val_q;
        ex_rs2_val_d    = ex_rs2_val_q;
        ex_imm_d        = ex_imm_q;
        ex_rs1_d        = ex_rs1_q;
        ex_rs2_d        = ex_rs2_q;
        ex_rd_d         = ex_rd_q;
        ex_alu_ctrl_d   = ex_alu_ctrl_q;
        ex_alu_src_d    = ex_alu_src_q;
        ex_reg_write_d  = ex_reg_write_q;
        ex_mem_read_d   = ex_mem_read_q;
        ex_mem_write_d  = ex_mem_write_q;
        ex_branch_d     = ex_branch_q;
        ex_jump_d       = ex_jump_q;
        ex_result_src_d = ex_result_src_q;
        ex_illegal_d    = ex_illegal_q;
        if (bus.flush) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_mem_write_d = 1'b0;
            ex_branch_d    = 1'b0;
            ex_jump_d      = 1'b0;
        end else if (bus.stall) begin
            // Hold everything.
        end else if (hazard) begin
            ex_valid_d     = 1'b0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
            ex_mem_write_d = 1'b0;
        end else begin
            ex_valid_d      = bus.if_valid;
            ex_pc_d         = bus.if_pc;
            ex_rs1_val_d    = rs1_val;
            ex_rs2_val_d    = rs2_val;
            ex_imm_d        = imm;
            ex_rs1_d        = rs1_idx;
            ex_rs2_d        = rs2_idx;
            ex_rd_d         = rd_idx;
            ex_alu_ctrl_d   = dec.alu_ctrl;
            ex_alu_src_d    = dec.alu_src;
            ex_reg_write_d  = bus.if_valid && dec.reg_write;
            ex_mem_read_d   = bus.if_valid && dec.mem_read;
            ex_mem_write_d  = bus.if_valid && dec.mem_write;
            ex_branch_d     = bus.if_valid && dec.branch;
            ex_jump_d       = bus.if_valid && dec.jump;
            ex_result_src_d = dec.result_src;
            ex_illegal_d    = bus.if_valid && dec.illegal;
        end
    end

    // ID/EX register bank with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid_q      <= 1'b0;
            ex_pc_q         <= RESET_PC;
            ex_rs1_val_q    <= '0;
            ex_rs2_val_q    <= '0;
            ex_imm_q        <= '0;
            ex_rs1_q        <= '0;
            ex_rs2_q        <= '0;
            ex_rd_q         <= '0;
            ex_alu_ctrl_q   <= ALU_ADD;
            ex_alu_src_q    <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            ex_mem_write_q  <= 1'b0;
            ex_branch_q     <= 1'b0;
            ex_jump_q       <= 1'b0;
            ex_result_src_q <= RES_ALU;
            ex_illegal_q    <= 1'b0;
        end else begin
            ex_valid_q      <= ex_valid_d;
            ex_pc_q         <= ex_pc_d;
            ex_rs1_val_q    <= ex_rs1_val_d;
            ex_rs2_val_q    <= ex_rs2_val_d;
            ex_imm_q        <= ex_imm_d;
            ex_rs1_q        <= ex_rs1_d;
            ex_rs2_q        <= ex_rs2_d;
            ex_rd_q         <= ex_rd_d;
            ex_alu_ctrl_q   <= ex_alu_ctrl_d;
            ex_alu_src_q    <= ex_alu_src_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            ex_mem_write_q  <= ex_mem_write_d;
            ex_branch_q     <= ex_branch_d;
            ex_jump_q       <= ex_jump_d;
            ex_result_src_q <= ex_result_src_d;
            ex_illegal_q    <= ex_illegal_d;
        end
    end

    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_pc         = ex_pc_q;
    assign bus.ex_rs1_val    = ex_rs1_val_q;
    assign bus.ex_rs2_val    = ex_rs2_val_q;
    assign bus.ex_imm        = ex_imm_q;
    assign bus.ex_rs1        = ex_rs1_q;
    assign bus.ex_rs2        = ex_rs2_q;
    assign bus.ex_rd         = ex_rd_q;
    assign bus.ex_alu_ctrl   = ex_alu_ctrl_q;
    assign bus.ex_alu_src    = ex_alu_src_q;
    assign bus.ex_reg_write  = ex_reg_write_q;
    assign bus.ex_mem_read   = ex_mem_read_q;
    assign bus.ex_mem_write  = ex_mem_write_q;
    assign bus.ex_branch     = ex_branch_q;
    assign bus.ex_jump       = ex_jump_q;
    assign bus.ex_result_src = ex_result_src_q;
    assign bus.ex_illegal    = ex_illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: table of single-instruction decode vectors plus
// hand-written sequences for load-use, stall/flush priority and reset.
module tb_id_ex_stage;
    import rv32i_pkg::*;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

    logic clk;
    logic rst;
    logic [31:0] rf [32];

    int n_tests = 0;
    int n_fail  = 0;

    id_ex_stage_if bus ();

    id_ex_stage #(
        .XLEN     (32),
        .RESET_PC (TB_RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Register-file model: asynchronous read of the addresses the DUT drives.
    assign bus.rf_rd1 = rf[bus.rf_a1];
    assign bus.rf_rd2 = rf[bus.rf_a2];

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        wb_we;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic        chk_imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [3:0]  alu;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic [1:0]  result_src;
        logic        illegal;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [31:0] instr,
                           input logic wb_we, input logic [4:0] wb_rd, input logic [31:0] wb_data,
                           input logic [31:0] rs1_val, input logic [31:0] rs2_val,
                           input logic [31:0] imm, input logic chk_imm,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [3:0] alu, input logic alu_src, input logic reg_write,
                           input logic mem_read, input logic mem_write, input logic branch,
                           input logic jump, input logic [1:0] result_src, input logic illegal);
        vec_t v;
        v.name = name; v.instr = instr; v.wb_we = wb_we; v.wb_rd = wb_rd; v.wb_data = wb_data;
        v.rs1_val = rs1_val; v.rs2_val = rs2_val; v.imm = imm; v.chk_imm = chk_imm;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.alu = alu; v.alu_src = alu_src;
        v.reg_write = reg_write; v.mem_read = mem_read; v.mem_write = mem_write;
        v.branch = branch; v.jump = jump; v.result_src = result_src; v.illegal = illegal;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
        bus.if_valid = valid;
        bus.if_instr = instr;
        bus.if_pc    = pc;
    endtask

    // One cycle with no valid instruction so EX is empty afterwards.
    task automatic idle_cycle();
        @(negedge clk);
        drive(1'b0, 32'h0000_0013, 32'h0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.wb_we = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0000_1000 + i;
        rf[0] = 32'h0000_DEAD;   // junk on the x0 port must never reach EX
        rf[5] = 32'd6;
        rf[6] = 32'h0000_000A;

        drive(1'b0, 32'h0000_0013, 32'h0);
        bus.stall   = 1'b0;
        bus.flush   = 1'b0;
        bus.wb_we   = 1'b0;
        bus.wb_rd   = 5'd0;
        bus.wb_data = 32'h0;

        // Reset.
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.ex_valid",     bus.ex_valid, 1'b0);
        check("reset.ex_pc",        bus.ex_pc, TB_RESET_PC);
        check("reset.ex_reg_write", bus.ex_reg_write, 1'b0);
        check("reset.ex_mem_read",  bus.ex_mem_read, 1'b0);
        check("reset.ex_imm",       bus.ex_imm, 32'h0);
        check("reset.ex_rd",        bus.ex_rd, 5'd0);
        check("reset.ex_rs1_val",   bus.ex_rs1_val, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Combinational read addresses.
        @(negedge clk);
        drive(1'b1, 32'h0062_83B3, 32'h0);
        #1;
        check("rf_a1", bus.rf_a1, 5'd5);
        check("rf_a2", bus.rf_a2, 5'd6);

        //       name       instr         we  wbrd   wbdata        rs1v          rs2v          imm           ci rs1 rs2 rd   alu        src rw mr mw br j  res ill
        add_vec("add",     32'h0062_83B3, 0, 5'd0, 32'h0,        32'd6,        32'hA,        32'h0,        0, 5, 6, 7,  ALU_ADD,   0, 1, 0, 0, 0, 0, 0, 0);
        add_vec("lw",      32'hFFC2_A383, 0, 5'd0, 32'h0,        32'd6,        32'h0,        32'hFFFFFFFC, 1, 5, 0, 7,  ALU_ADD,   1, 1, 1, 0, 0, 0, 1, 0);
        add_vec("byp_rs1", 32'h0062_83B3, 1, 5'd5, 32'h55,       32'h55,       32'hA,        32'h0,        0, 5, 6, 7,  ALU_ADD,   0, 1, 0, 0, 0, 0, 0, 0);
        add_vec("byp_x0",  32'h0062_83B3, 1, 5'd0, 32'h55,       32'd6,        32'hA,        32'h0,        0, 5, 6, 7,  ALU_ADD,   0, 1, 0, 0, 0, 0, 0, 0);
        add_vec("addi_x0", 32'h0050_0093, 0, 5'd0, 32'h0,        32'h0,        32'h0,        32'd5,        1, 0, 0, 1,  ALU_ADD,   1, 1, 0, 0, 0, 0, 0, 0);
        add_vec("byp_wx0", 32'h0050_0093, 1, 5'd0, 32'h77,       32'h0,        32'h0,        32'd5,        1, 0, 0, 1,  ALU_ADD,   1, 1, 0, 0, 0, 0, 0, 0);
        add_vec("illegal", 32'h0000_03FF, 0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0,  ALU_ADD,   0, 0, 0, 0, 0, 0, 0, 1);
        add_vec("sub",     32'h4020_81B3, 0, 5'd0, 32'h0,        32'h1001,     32'h1002,     32'h0,        0, 1, 2, 3,  ALU_SUB,   0, 1, 0, 0, 0, 0, 0, 0);
        add_vec("sw",      32'h0062_A423, 0, 5'd0, 32'h0,        32'd6,        32'hA,        32'd8,        1, 5, 6, 0,  ALU_ADD,   1, 0, 0, 1, 0, 0, 0, 0);
        add_vec("beq",     32'hFE62_8CE3, 1, 5'd6, 32'h66,       32'd6,        32'h66,       32'hFFFFFFF8, 1, 5, 6, 0,  ALU_SUB,   0, 0, 0, 0, 1, 0, 0, 0);
        add_vec("lui",     32'h1234_5537, 0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h12345000, 1, 0, 0, 10, ALU_PASSB, 1, 1, 0, 0, 0, 0, 0, 0);
        add_vec("auipc",   32'h0000_1117, 0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h00001000, 1, 0, 0, 2,  ALU_ADD,   1, 1, 0, 0, 0, 0, 0, 0);
        add_vec("jal",     32'h0100_00EF, 0, 5'd0, 32'h0,        32'h0,        32'h0,        32'd16,       1, 0, 0, 1,  ALU_ADD,   1, 1, 0, 0, 0, 1, 2, 0);
        add_vec("jalr",    32'h0000_8067, 0, 5'd0, 32'h0,        32'h1001,     32'h0,        32'h0,        1, 1, 0, 0,  ALU_ADD,   1, 1, 0, 0, 0, 1, 2, 0);
        add_vec("srai",    32'h4032_D213, 0, 5'd0, 32'h0,        32'd6,        32'h0,        32'h403,      1, 5, 0, 4,  ALU_SRA,   1, 1, 0, 0, 0, 0, 0, 0);
        add_vec("fence",   32'h0000_000F, 0, 5'd0, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0,  ALU_ADD,   0, 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            vec_t v;
            logic [31:0] pc;
            v  = vecs[i];
            pc = 32'h200 + 32'(i) * 4;
            idle_cycle();
            @(negedge clk);
            drive(1'b1, v.instr, pc);
            bus.wb_we   = v.wb_we;
            bus.wb_rd   = v.wb_rd;
            bus.wb_data = v.wb_data;
            @(posedge clk);
            #1;
            bus.wb_we = 1'b0;
            check({v.name, ".ex_valid"},      bus.ex_valid, 1'b1);
            check({v.name, ".ex_pc"},         bus.ex_pc, pc);
            check({v.name, ".ex_rs1_val"},    bus.ex_rs1_val, v.rs1_val);
            check({v.name, ".ex_rs2_val"},    bus.ex_rs2_val, v.rs2_val);
            if (v.chk_imm) check({v.name, ".ex_imm"}, bus.ex_imm, v.imm);
            check({v.name, ".ex_rs1"},        bus.ex_rs1, v.rs1);
            check({v.name, ".ex_rs2"},        bus.ex_rs2, v.rs2);
            check({v.name, ".ex_rd"},         bus.ex_rd, v.rd);
            check({v.name, ".ex_alu_ctrl"},   bus.ex_alu_ctrl, v.alu);
            check({v.name, ".ex_alu_src"},    bus.ex_alu_src, v.alu_src);
            check({v.name, ".ex_reg_write"},  bus.ex_reg_write, v.reg_write);
            check({v.name, ".ex_mem_read"},   bus.ex_mem_read, v.mem_read);
            check({v.name, ".ex_mem_write"},  bus.ex_mem_write, v.mem_write);
            check({v.name, ".ex_branch"},     bus.ex_branch, v.branch);
            check({v.name, ".ex_jump"},       bus.ex_jump, v.jump);
            check({v.name, ".ex_result_src"}, bus.ex_result_src, v.result_src);
            check({v.name, ".ex_illegal"},    bus.ex_illegal, v.illegal);
        end

        // Invalid fetch slot leaves EX empty.
        idle_cycle();
        check("novalid.ex_valid", bus.ex_valid, 1'b0);

        // Load-use: lw x7 then add x8,x7,x6 -> one bubble, then the add.
        idle_cycle();
        @(negedge clk);
        drive(1'b1, 32'hFFC2_A383, 32'h300);
        #1;
        check("lu.haz_before", bus.hazard_stall, 1'b0);
        @(posedge clk);
        #1;
        check("lu.lw_mem_read", bus.ex_mem_read, 1'b1);
        @(negedge clk);
        drive(1'b1, 32'h0063_8433, 32'h304);
        #1;
        check("lu.haz_set", bus.hazard_stall, 1'b1);
        @(posedge clk);
        #1;
        check("lu.bubble_valid",     bus.ex_valid, 1'b0);
        check("lu.bubble_mem_read",  bus.ex_mem_read, 1'b0);
        check("lu.bubble_reg_write", bus.ex_reg_write, 1'b0);
        check("lu.haz_clear",        bus.hazard_stall, 1'b0);
        @(posedge clk);
        #1;
        check("lu.add_valid",   bus.ex_valid, 1'b1);
        check("lu.add_rs1",     bus.ex_rs1, 5'd7);
        check("lu.add_rd",      bus.ex_rd, 5'd8);
        check("lu.add_pc",      bus.ex_pc, 32'h304);
        check("lu.add_rs1_val", bus.ex_rs1_val, 32'h1007);

        // Stall holds EX for 3 cycles and masks the load-use hazard.
        idle_cycle();
        @(negedge clk);
        drive(1'b1, 32'hFFC2_A383, 32'h310);
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.stall = 1'b1;
            drive(1'b1, (c == 0) ? 32'h0063_8433 : 32'h1234_5537, 32'h314 + 32'(c) * 4);
            #1;
            check("stall.haz_masked", bus.hazard_stall, 1'b0);
            @(posedge clk);
            #1;
            check("stall.ex_valid", bus.ex_valid, 1'b1);
            check("stall.ex_pc",    bus.ex_pc, 32'h310);
            check("stall.ex_rd",    bus.ex_rd, 5'd7);
            check("stall.ex_imm",   bus.ex_imm, 32'hFFFFFFFC);
            check("stall.ex_mem_read", bus.ex_mem_read, 1'b1);
        end
        @(negedge clk);
        bus.stall = 1'b0;
        drive(1'b1, 32'h0063_8433, 32'h320);
        #1;
        check("stall.haz_after", bus.hazard_stall, 1'b1);
        @(posedge clk);
        #1;
        check("stall.bubble", bus.ex_valid, 1'b0);

        // Flush beats stall; flush alone kills; then normal capture.
        idle_cycle();
        @(negedge clk);
        drive(1'b1, 32'h0062_83B3, 32'h400);
        @(posedge clk);
        #1;
        check("fl.captured", bus.ex_valid, 1'b1);
        @(negedge clk);
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        @(posedge clk);
        #1;
        check("fl.flush_stall", bus.ex_valid, 1'b0);
        @(negedge clk);
        bus.stall = 1'b0;
        @(posedge clk);
        #1;
        check("fl.flush_only", bus.ex_valid, 1'b0);
        @(negedge clk);
        bus.flush = 1'b0;
        drive(1'b1, 32'h0062_83B3, 32'h404);
        @(posedge clk);
        #1;
        check("fl.resume_valid", bus.ex_valid, 1'b1);
        check("fl.resume_pc",    bus.ex_pc, 32'h404);

        // Asynchronous reset mid-stream, between clock edges.
        #2 rst = 1'b0;
        #1;
        check("arst.ex_valid",     bus.ex_valid, 1'b0);
        check("arst.ex_pc",        bus.ex_pc, TB_RESET_PC);
        check("arst.ex_reg_write", bus.ex_reg_write, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode stage plus ID/EX pipeline register for the RV32I core.
- Takes the fetched instruction, drives the register-file read addresses and control fields, and captures the operands and decoded control into EX-stage registers.
- Bypasses a same-cycle writeback into the captured operands.
- Detects load-use hazards and inserts a bubble.

Parameters:
- XLEN, 32, datapath width (only 32 is supported).
- RESET_PC, 32'h00000000, reset value of ex_pc.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_valid  in  1  if_instr/if_pc hold a valid instruction.
- if_instr  in  32  instruction word.
- if_pc  in  32  PC of if_instr.
- stall  in  1  downstream stall; hold EX registers.
- flush  in  1  branch/jump redirect; kill the instruction entering EX.
- rf_a1  out  5  register-file read address 1 = if_instr[19:15] (combinational).
- rf_a2  out  5  register-file read address 2 = if_instr[24:20] (combinational).
- rf_rd1  in  32  register-file read data 1.
- rf_rd2  in  32  register-file read data 2.
- wb_we  in  1  writeback write enable (same signal as the register-file WE3).
- wb_rd  in  5  writeback destination (same as A3).
- wb_data  in  32  writeback data (same as WD3).
- hazard_stall  out  1  combinational; high when fetch must hold.
- ex_valid  out  1  EX-stage instruction valid.
- ex_pc  out  32  captured PC.
- ex_rs1_val, ex_rs2_val  out  32 each  captured operands.
- ex_imm  out  32  sign-extended immediate.
- ex_rs1, ex_rs2, ex_rd  out  5 each  captured register indices.
- ex_alu_ctrl  out  4  ALU operation code (package enum).
- ex_alu_src  out  1  selects the second ALU operand: 0 = rs2, 1 = imm.
- ex_reg_write  out  1  instruction writes rd.
- ex_mem_read  out  1  load.
- ex_mem_write  out  1  store.
- ex_branch  out  1  branch.
- ex_jump  out  1  JAL or JALR.
- ex_result_src  out  2  writeback source: 0 = ALU, 1 = memory, 2 = PC+4.
- ex_illegal  out  1  unsupported opcode.

Behaviour:
- Reset (rst=0, asynchronous): every ex_* output is 0, except ex_pc = RESET_PC.
- Reset mid-stream drops the EX instruction; ex_valid returns to 0 immediately.
- Decode is combinational from if_instr and supports the RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE and SYSTEM.
- FENCE and SYSTEM decode as a NOP with reg_write=0.
- Any other opcode sets illegal=1 with all write and memory enables forced to 0.
- Immediate formats (sign bit is instr[31]):
  - I-type: {instr[31:20]}.
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type: {instr[31:12], 12'b0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Register index usage:
  - rs1 is unused for LUI, AUIPC and JAL.
  - rs2 is used only by BRANCH, STORE and OP.
  - Unused indices are captured as 0.
- Operand bypass:
  - If wb_we=1 and wb_rd!=0 and wb_rd==rs1, capture wb_data instead of rf_rd1. The same rule applies to rs2 with rf_rd2.
  - An operand with index 0 is always captured as 32'h0, regardless of rf_rd or the bypass.
- Load-use hazard: hazard_stall = if_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((rs1 used & ex_rd==rs1) | (rs2 used & ex_rd==rs2)).
- Register update on each clock edge, highest priority first:
  1. flush=1: ex_valid <= 0; the other ex_* registers are don't-care.
  2. stall=1: hold all ex_* registers.
  3. hazard_stall=1: insert a bubble (ex_valid <= 0, ex_reg_write, ex_mem_read and ex_mem_write <= 0).
  4. Otherwise: capture the decode; ex_valid <= if_valid.
- A bubble forces ex_reg_write, ex_mem_read and ex_mem_write to 0 (ex_valid=0 also blocks them).
- Latency is one cycle, fetch to EX; throughput is one instruction per cycle with no hazards.
- hazard_stall is a function of current state only, with no input-to-output path except if_instr and if_valid.
- hazard_stall is masked while stall=1: the upstream stage must hold on (stall | hazard_stall).

Decomposition:
- Package rv32i_pkg holds:
  - opcode localparams (OP_LUI=7'b0110111 … OP_SYSTEM=7'b1110011);
  - the ALU control enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB) with fixed 4-bit codes;
  - the imm_type enum (I, S, B, U, J);
  - the result_src codes.
- One sub-module, imm_gen: combinational, (instr, imm_type) -> imm.
- The main decoder and pipeline register stay in id_ex_stage.

Test Plan:
- Basic decode: register file x5=6, x6=0xA; instr 0x006283B3 (add x7,x5,x6), if_valid=1.
  -> Next cycle: ex_valid=1, ex_rs1_val=6, ex_rs2_val=0xA, ex_rd=7, alu_ctrl=ADD, reg_write=1, alu_src=0.
- Immediate: instr 0xFFC2A383 (lw x7,-4(x5)).
  -> ex_imm=0xFFFFFFFC, mem_read=1, result_src=1, alu_src=1.
- Load-use: lw above, then instr 0x00638433 (add x8,x7,x6).
  -> hazard_stall=1 for one cycle, bubble ex_valid=0, then add captured with ex_rs1=7.
- Bypass and x0: wb_we=1, wb_rd=5, wb_data=0x55 while add x7,x5,x6 is decoded.
  -> ex_rs1_val=0x55.
  - With wb_rd=0: ex_rs1_val=rf_rd1.
  - With rs1=0 (addi x1,x0,5): ex_rs1_val=0 even if rf_rd1=0xDEAD.
- Control priority: flush and stall asserted together -> ex_valid=0. Stall alone for 3 cycles -> ex_* held constant.
- Reset and illegal: assert rst=0 mid-stream -> ex_valid=0 immediately, ex_pc=RESET_PC. Opcode 7'b1111111 -> ex_illegal=1, reg_write=0, mem_write=0.
